serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// around a single-bit full-subtractor cell with a start/done handshake.

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] wr;
    logic           br;
    logic [CW-1:0]  cnt;

    logic           load;
    logic           step;
    logic           last_bit;
    logic           d_bit;
    logic           br_nxt;
    logic [WIDTH-1:0] wr_nxt;

    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    assign wr_nxt   = {d_bit, wr[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The final bit is folded straight into diff so the result lands on the SHIFT->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            wr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= borrow_in;
            wr  <= '0;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            wr  <= wr_nxt;
            br  <= br_nxt;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                diff       <= wr_nxt;
                borrow_out <= br_nxt;
            end
        end
    end
endmodule
